// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
//
// Takes rs1/rs2 straight from the register file read ports. It resolves
// MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in 32 single-bit iterations. It hands
// the result back with its destination address for write-back.
//
// Ports:
//   ip_clk      clock, rising edge
//   ip_rst      asynchronous active-high reset
//   ip_start    request pulse, only honoured in IDLE
//   ip_funct3   RV32M op select
//   ip_rs1      operand A (multiplicand / dividend)
//   ip_rs2      operand B (multiplier / divisor)
//   ip_rd_addr  destination register address
//   ip_flush    synchronous abort, wins over ip_start
//   op_busy     high while an operation is in flight (CALC/FIX/DONE)
//   op_done     one-cycle result-valid pulse
//   op_wr_en    register-file write enable (op_done with rd != 0)
//   op_rd_addr  destination address of the delivered result
//   op_result   result, held until the next op_done
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            ip_clk,
  input  logic            ip_rst,
  input  logic            ip_start,
  input  logic [2:0]      ip_funct3,
  input  logic [XLEN-1:0] ip_rs1,
  input  logic [XLEN-1:0] ip_rs2,
  input  logic [4:0]      ip_rd_addr,
  input  logic            ip_flush,
  output logic            op_busy,
  output logic            op_done,
  output logic            op_wr_en,
  output logic [4:0]      op_rd_addr,
  output logic [XLEN-1:0] op_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [2:0]      funct3_reg;
  logic [4:0]      rd_reg;
  // Multiply: a_reg = multiplier (shifts out LSB-first, collects product low half).
  // Divide:   a_reg = dividend (shifts out MSB-first, collects quotient bits).
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;      // multiplicand magnitude / divisor magnitude
  logic [XLEN:0]   hi_reg;     // product high half + carry / partial remainder
  logic [XLEN-1:0] res_reg;    // corrected result waiting for DONE
  logic            neg_reg;    // negate the selected result in FIX
  logic [CW-1:0]   cnt_reg;

  // ---------------- operand decode at acceptance ----------------
  logic            in_is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            neg_in;
  logic            start_ok;

  always_comb begin
    in_is_div  = ip_funct3[2];
    // DIV/REM signed on both; MUL/MULH signed on both; MULHSU only rs1.
    rs1_signed = in_is_div ? ~ip_funct3[0] : (ip_funct3[1:0] != 2'b11);
    rs2_signed = in_is_div ? ~ip_funct3[0] : ~ip_funct3[1];
    rs1_neg    = rs1_signed & ip_rs1[XLEN-1];
    rs2_neg    = rs2_signed & ip_rs2[XLEN-1];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    rs1_mag    = rs1_neg ? -ip_rs1 : ip_rs1;
    rs2_mag    = rs2_neg ? -ip_rs2 : ip_rs2;

    div_zero   = in_is_div & (ip_rs2 == '0);
    div_ovf    = in_is_div & ~ip_funct3[0] &
                 (ip_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (ip_rs2 == '1);
    special    = div_zero | div_ovf;

    special_res = '0;
    if (div_zero) begin
      special_res = ip_funct3[1] ? ip_rs1 : '1;
    end else if (div_ovf) begin
      special_res = ip_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Remainder follows the dividend sign; product and quotient follow the xor.
    neg_in = (in_is_div & ip_funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);

    start_ok = (state_reg == S_IDLE) & ip_start & ~ip_flush;
  end

  // ---------------- per-iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_val, div_fix, fix_res;

  always_comb begin
    mul_sum   = hi_reg + {1'b0, (a_reg[0] ? b_reg : {XLEN{1'b0}})};
    // Partial remainder stays below the divisor, so its top bit is always 0.
    div_shift = {hi_reg[XLEN-1:0], a_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_reg};

    prod     = {hi_reg[XLEN-1:0], a_reg};
    prod_fix = neg_reg ? -prod : prod;
    div_val  = funct3_reg[1] ? hi_reg[XLEN-1:0] : a_reg;
    div_fix  = neg_reg ? -div_val : div_val;

    if (funct3_reg[2]) begin
      fix_res = div_fix;
    end else if (funct3_reg[1:0] == 2'b00) begin
      fix_res = prod_fix[XLEN-1:0];
    end else begin
      fix_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_busy    = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: if (start_ok) state_next = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_reg == '0) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (ip_flush) begin
      state_next = S_IDLE;
    end
  end

  // ---------------- datapath registers and outputs ----------------
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      funct3_reg <= '0;
      rd_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      res_reg    <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      op_done    <= 1'b0;
      op_wr_en   <= 1'b0;
      op_rd_addr <= '0;
      op_result  <= '0;
    end else begin
      op_done  <= 1'b0;
      op_wr_en <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            funct3_reg <= ip_funct3;
            rd_reg     <= ip_rd_addr;
            a_reg      <= in_is_div ? rs1_mag : rs2_mag;
            b_reg      <= in_is_div ? rs2_mag : rs1_mag;
            hi_reg     <= '0;
            neg_reg    <= neg_in;
            cnt_reg    <= CW'(XLEN - 1);
            if (special) begin
              res_reg <= special_res;
            end
          end
        end
        S_CALC: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (funct3_reg[2]) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            if (!div_diff[XLEN]) begin
              hi_reg <= div_diff;
              a_reg  <= {a_reg[XLEN-2:0], 1'b1};
            end else begin
              hi_reg <= div_shift;
              a_reg  <= {a_reg[XLEN-2:0], 1'b0};
            end
          end else begin
            // Shift-add: the 65-bit {hi, a} pair shifts right once per step.
            hi_reg <= {1'b0, mul_sum[XLEN:1]};
            a_reg  <= {mul_sum[0], a_reg[XLEN-1:1]};
          end
        end
        S_FIX: begin
          res_reg <= fix_res;
        end
        S_DONE: begin
          if (!ip_flush) begin
            op_done    <= 1'b1;
            op_wr_en   <= (rd_reg != 5'd0);
            op_rd_addr <= rd_reg;
            op_result  <= res_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, random ops
// against a plain-arithmetic reference, and busy/flush/reset robustness.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        flush = 1'b0;
  logic        busy, done, wr_en;
  logic [4:0]  rd_addr_o;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .ip_clk     (clk),
    .ip_rst     (rst),
    .ip_start   (start),
    .ip_funct3  (funct3),
    .ip_rs1     (rs1),
    .ip_rs2     (rs2),
    .ip_rd_addr (rd_addr),
    .ip_flush   (flush),
    .op_busy    (busy),
    .op_done    (done),
    .op_wr_en   (wr_en),
    .op_rd_addr (rd_addr_o),
    .op_result  (result)
  );

  // Reference: RV32M semantics computed with 64-bit host arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs, ps;
    logic [63:0] ua, ub, pu;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ubs = ub;
    model = 32'd0;
    case (f3)
      3'd0: begin ps = sa * sb;  model = ps[31:0];  end
      3'd1: begin ps = sa * sb;  model = ps[63:32]; end
      3'd2: begin ps = sa * ubs; model = ps[63:32]; end
      3'd3: begin pu = ua * ub;  model = pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) model = 32'hFFFF_FFFF;
        else begin ps = sa / sb; model = ps[31:0]; end
      end
      3'd5: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) model = a;
        else begin ps = sa % sb; model = ps[31:0]; end
      end
      default: model = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and waits for op_done (bounded). Observations only; callers compare.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic wr,
                       output logic [4:0] rd_o, output int lat, output bit busy_ok);
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1 = $urandom; rs2 = $urandom; rd_addr = 5'($urandom); funct3 = 3'($urandom);
    busy_ok = (busy === 1'b1);
    lat = -1; res = 32'd0; wr = 1'b0; rd_o = 5'd0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k; res = result; wr = wr_en; rd_o = rd_addr_o;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({busy, done, wr_en, rd_addr_o, result} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b wr=%b rd=%0d res=%h, want all 0",
               busy, done, wr_en, rd_addr_o, result);
    end
    n_checks++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    n_checks++;
    $display("reset: outputs cleared, unit idle");
  endtask

  task automatic test_directed();
    logic [2:0]  vf [14];
    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic [31:0] ve [14];
    int          vl [14];
    logic [31:0] res; logic wr; logic [4:0] rd_o; int lat; bit bok;
    vf = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    va = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
           32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
           32'hFFFF_FFFB, 32'hFFFF_FFFB};
    vb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    ve = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vl = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 14; i++) begin
      do_op(vf[i], va[i], vb[i], 5'(i + 5), res, wr, rd_o, lat, bok);
      $display("directed[%0d]: f3=%0d a=%h b=%h -> res=%h lat=%0d wr=%b rd=%0d",
               i, vf[i], va[i], vb[i], res, lat, wr, rd_o);
      if (res !== ve[i]) begin
        n_fail++; $display("FAIL dir_result[%0d]: got %h want %h", i, res, ve[i]);
      end
      n_checks++;
      if (lat != vl[i]) begin
        n_fail++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, vl[i]);
      end
      n_checks++;
      if (wr !== 1'b1 || rd_o !== 5'(i + 5)) begin
        n_fail++; $display("FAIL dir_wb[%0d]: got wr=%b rd=%0d want wr=1 rd=%0d", i, wr, rd_o, i + 5);
      end
      n_checks++;
      if (!bok) begin
        n_fail++; $display("FAIL dir_busy[%0d]: busy dropped before done, want held high", i);
      end
      n_checks++;
      // One cycle later: pulse gone, result held.
      @(posedge clk); #1;
      if (done !== 1'b0 || wr_en !== 1'b0 || result !== ve[i] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_hold[%0d]: got done=%b wr=%b busy=%b res=%h want 0 0 0 %h",
                 i, done, wr_en, busy, result, ve[i]);
      end
      n_checks++;
    end
  endtask

  task automatic test_rd_zero();
    logic [31:0] res; logic wr; logic [4:0] rd_o; int lat; bit bok;
    do_op(3'd0, 32'd3, 32'd5, 5'd0, res, wr, rd_o, lat, bok);
    $display("rd_zero: res=%h lat=%0d wr=%b", res, lat, wr);
    if (lat != 34 || wr !== 1'b0 || res !== 32'd15) begin
      n_fail++;
      $display("FAIL rd_zero: got lat=%0d wr=%b res=%h want 34 0 0000000f", lat, wr, res);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [31:0] res; logic wr; logic [4:0] rd_o; int lat; bit bok;
    logic [2:0] f3; logic [31:0] a, b, exp; logic [4:0] rd; int exp_lat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
      exp = model(f3, a, b);
      exp_lat = is_special(f3, a, b) ? 1 : 34;
      do_op(f3, a, b, rd, res, wr, rd_o, lat, bok);
      $display("random[%0d]: f3=%0d a=%h b=%h rd=%0d -> res=%h lat=%0d", i, f3, a, b, rd, res, lat);
      if (res !== exp || lat != exp_lat || wr !== (rd != 5'd0) || rd_o !== rd) begin
        n_fail++;
        $display("FAIL rand[%0d]: got res=%h lat=%0d wr=%b rd=%0d want res=%h lat=%0d wr=%b rd=%0d",
                 i, res, lat, wr, rd_o, exp, exp_lat, rd != 5'd0, rd);
      end
      n_checks++;
    end
  endtask

  task automatic test_back_to_back();
    int lat = -1; int extra = 0;
    logic [31:0] res = 32'd0; logic [4:0] rd_o = 5'd0;
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; rd_addr = 5'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_addr = 5'd10; start = 1'b1;
      end
      @(posedge clk); #1; start = 1'b0;
      if (done === 1'b1) begin lat = k; res = result; rd_o = rd_addr_o; break; end
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    $display("back_to_back: res=%h rd=%0d lat=%0d extra_done=%0d", res, rd_o, lat, extra);
    if (res !== 32'd142 || rd_o !== 5'd9 || lat != 34) begin
      n_fail++;
      $display("FAIL b2b_first: got res=%h rd=%0d lat=%0d want 0000008e 9 34", res, rd_o, lat);
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++; $display("FAIL b2b_ignored: got %0d extra done pulses want 0", extra);
    end
    n_checks++;
  endtask

  task automatic test_flush();
    int seen = 0;
    logic [31:0] res; logic wr; logic [4:0] rd_o; int lat; bit bok;
    logic [31:0] a, b;
    @(negedge clk);
    funct3 = 3'd3; rs1 = $urandom; rs2 = $urandom; rd_addr = 5'd11; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    $display("flush: busy after flush=%b done=%b", busy, done);
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_quiet: got %0d done/busy cycles want 0", seen);
    end
    n_checks++;
    // Flush and start together in IDLE: the start must be dropped.
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_priority: got busy=%b want 0", busy);
    end
    n_checks++;
    a = $urandom; b = $urandom_range(1, 1000);
    do_op(3'd6, a, b, 5'd12, res, wr, rd_o, lat, bok);
    $display("flush_after: REM a=%h b=%h -> res=%h lat=%0d", a, b, res, lat);
    if (res !== model(3'd6, a, b) || lat != 34) begin
      n_fail++;
      $display("FAIL flush_after: got res=%h lat=%0d want %h 34", res, lat, model(3'd6, a, b));
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    logic [31:0] res; logic wr; logic [4:0] rd_o; int lat; bit bok;
    @(negedge clk);
    funct3 = 3'd4; rs1 = $urandom; rs2 = 32'd3; rd_addr = 5'd13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("reset_mid: busy=%b done=%b wr=%b rd=%0d res=%h", busy, done, wr_en, rd_addr_o, result);
    if ({busy, done, wr_en, rd_addr_o, result} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b wr=%b rd=%0d res=%h want all 0",
               busy, done, wr_en, rd_addr_o, result);
    end
    n_checks++;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %0d done/busy cycles want 0", seen);
    end
    n_checks++;
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, res, wr, rd_o, lat, bok);
    if (res !== 32'd0 || lat != 34) begin
      n_fail++; $display("FAIL reset_mid_after: got res=%h lat=%0d want 00000000 34", res, lat);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rd_zero();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the general register file.
- Consumes the rs1/rs2 operand values read from the register file, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations, and returns the result with its destination address for write-back.
- Holds the pipeline through op_busy while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported, and the iteration counter width is derived as clog2(XLEN).

Ports:
- ip_clk  input  1  clock, rising edge.
- ip_rst  input  1  reset, asynchronous, active-high.
- ip_start  input  1  request pulse; sampled only in IDLE.
- ip_funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ip_rs1  input  32  operand A (dividend/multiplicand), from register file op_rs1.
- ip_rs2  input  32  operand B (divisor/multiplier), from register file op_rs2.
- ip_rd_addr  input  5  destination register address.
- ip_flush  input  1  synchronous abort.
- op_busy  output  1  high from the cycle after start is accepted until op_done.
- op_done  output  1  one-cycle pulse: result valid.
- op_wr_en  output  1  write enable to register file; equals op_done & (op_rd_addr != 0).
- op_rd_addr  output  5  latched destination address.
- op_result  output  32  result; holds its value until the next op_done.

Behaviour:
- Reset: asynchronous, active-high, clock ip_clk. All outputs and internal registers clear to 0; state goes to IDLE. Reset mid-operation discards the operation and produces no op_done.
- FSM states and transitions:
  - IDLE: on ip_start=1 && ip_flush=0, latch funct3, rd_addr, operand magnitudes and result sign.
    - Special-case division (see below) → DONE.
    - Otherwise → CALC with counter=31.
  - CALC: one iteration per cycle.
    - counter==0 → FIX.
    - Otherwise counter decrements.
  - FIX: apply sign correction and select the result half → DONE.
  - DONE: assert op_done (and op_wr_en if rd≠0) for exactly one cycle, drive op_result → IDLE.
- Latency, with start sampled at edge N:
  - Normal ops: op_done high in the cycle after edge N+34 (CALC 32 cycles, FIX 1 cycle, DONE 1 cycle).
  - Special cases: op_done high in the cycle after edge N+1.
- Busy and flush:
  - op_busy=1 in CALC, FIX and DONE; op_busy=0 in IDLE.
  - ip_start outside IDLE is ignored; there is no queueing.
  - ip_flush=1 in any state → IDLE at the next edge, with no op_done.
  - ip_flush has priority over ip_start in the same cycle.
- Multiply:
  - Signedness: rs1 is signed for MUL/MULH/MULHSU; rs2 is signed for MUL/MULH only.
  - Convert operands to magnitudes, then run unsigned radix-2 shift-add into a 64-bit accumulator.
  - FIX negates the 64-bit product (two's complement) when the signs differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Unsigned restoring division on magnitudes: 32-bit quotient and 33-bit partial remainder.
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, resolved in IDLE with no CALC:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned; no overflow is possible in the datapath.
- Operands are captured at acceptance; later changes on ip_rs1/ip_rs2 have no effect.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → 34 cycles later op_done=1, op_wr_en=1, op_rd_addr=5, op_result=0xFFFFFFEB; op_busy high throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 (0xFFFFFFF9) ÷ 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 ÷ 7 → 14. REMU 100 ÷ 7 → 2.
- DIVU 0x1234 ÷ 0 → 0xFFFFFFFF, and REMU 0x1234 ÷ 0 → 0x1234, each with op_done the cycle after the start edge. DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000 and REM → 0, also 1-cycle latency.
- Rd=0 check: MUL with rd=0 → op_done=1, op_wr_en=0.
- Robustness:
  - Second ip_start during CALC → ignored; only the first result is produced.
  - ip_flush at iteration 10 → op_busy drops next cycle, no op_done; a new op started afterwards is correct.
  - ip_rst asserted mid-CALC → outputs 0 immediately, IDLE.
